// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: mode encodings, CPOL/CPHA bit positions
// and the bit value shifted out when the transmit side has nothing queued.
package spi_pkg;

   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_e;

   localparam int   CPOL_BIT      = 1;
   localparam int   CPHA_BIT      = 0;
   localparam logic UNDERRUN_FILL = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count, count_next;
   logic              do_push, do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_comb begin
      // NOTE: default assignment first so every path drives count_next and no latch is inferred.
      count_next = count;
      if (do_push && !do_pop)
         count_next = count + ONE_CNT;
      else if (do_pop && !do_push)
         count_next = count - ONE_CNT;
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         full  <= (count_next == FULL_CNT);
         empty <= (count_next == '0);
      end
   end

   // NOTE: storage is deliberately not reset; the empty flag masks stale contents on head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spi_slave_fifo.sv
// Oversampled SPI slave supporting all four CPOL/CPHA modes, with a one-word
// TX holding register and an RX FIFO, both on valid/ready handshakes.
module spi_slave_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int RX_DEPTH    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              sck,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              tx_underrun,
   output logic              busy
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W-1);

   logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
   logic                   ss_d, sck_d;
   logic                   ss_s, sck_s, mosi_s;

   logic              active, cpol, cpha, first_shift;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] tx_shift, hold_reg, load_word, rx_word;
   logic [DATA_W-2:0] rx_shift;
   logic              hold_full;

   logic sel, sel_rise, sck_rise, sck_fall, lead, trail;
   logic sample_edge, shift_edge, word_done, load, tx_hs;
   logic rx_full, rx_empty, rx_pop;

   // ss flops reset low so a chip select still held across reset does not look like a new select.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= '0;
         sck_sync  <= '0;
         mosi_sync <= '0;
         ss_d      <= 1'b0;
         sck_d     <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_d      <= ss_sync[SYNC_STAGES-1];
         sck_d     <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sel      = ~ss_s;
   assign sel_rise = ~ss_s & ss_d;
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign lead     = cpol ? sck_fall : sck_rise;
   assign trail    = cpol ? sck_rise : sck_fall;

   assign sample_edge = active & sel & (cpha ? trail : lead);
   assign shift_edge  = active & sel & (cpha ? lead : trail);
   assign rx_word     = {rx_shift, mosi_s};
   assign word_done   = sample_edge & (bit_cnt == LAST_BIT);
   // The first CPHA=1 shift edge only presents the MSB loaded at select time.
   assign load        = sel_rise | (shift_edge & (bit_cnt == '0) & ~first_shift);
   assign load_word   = hold_full ? hold_reg : {DATA_W{UNDERRUN_FILL}};
   assign tx_hs       = tx_valid & ~hold_full;
   assign rx_pop      = rx_ready & ~rx_empty;

   assign tx_ready = ~hold_full;
   assign rx_valid = ~rx_empty;
   assign miso_oe  = active;
   assign busy     = active & (bit_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active      <= 1'b0;
         cpol        <= 1'b0;
         cpha        <= 1'b0;
         first_shift <= 1'b0;
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         hold_reg    <= '0;
         hold_full   <= 1'b0;
         miso        <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_overrun  <= word_done & rx_full & ~rx_pop;
         tx_underrun <= load & ~hold_full;

         if (tx_hs) begin
            hold_reg  <= tx_data;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end

         if (sel_rise) begin
            active      <= 1'b1;
            cpol        <= mode[CPOL_BIT];
            cpha        <= mode[CPHA_BIT];
            first_shift <= mode[CPHA_BIT];
            bit_cnt     <= '0;
            if (mode[CPHA_BIT])
               tx_shift <= load_word;
            else
               {miso, tx_shift} <= {load_word, 1'b0};
         end else if (!sel) begin
            active      <= 1'b0;
            first_shift <= 1'b0;
            bit_cnt     <= '0;
            miso        <= 1'b0;
         end else begin
            if (sample_edge) begin
               rx_shift <= rx_word[DATA_W-2:0];
               bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
            if (shift_edge) begin
               first_shift <= 1'b0;
               if (load)
                  {miso, tx_shift} <= {load_word, 1'b0};
               else
                  {miso, tx_shift} <= {tx_shift, 1'b0};
            end
         end
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (word_done),
      .push_data (rx_word),
      .pop       (rx_pop),
      .head      (rx_data),
      .full      (rx_full),
      .empty     (rx_empty)
   );

endmodule
